xbar_varlat_prio_ctrl: RTL and testbench



---
 rtl/xbar_varlat_pkg.sv | 10 +
 rtl/xbar_varlat_prio_bank.sv | 74 +++++++
 rtl/xbar_varlat_prio_ctrl.sv | 69 ++++++
 tb/tb_xbar_varlat_prio_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/xbar_varlat_pkg.sv
// xbar_varlat_pkg: shared FSM state type and pointer-wrap helper for the priority controller
package xbar_varlat_pkg;

   typedef enum logic {RR, LOCK} prio_state_e;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/xbar_varlat_prio_bank.sv
// xbar_varlat_prio_bank: per-bank round-robin pointer with a starvation lock FSM
module xbar_varlat_prio_bank
   import xbar_varlat_pkg::*;
#(
   parameter int unsigned NumIn    = 4,
   parameter int unsigned LogNumIn = 2
)(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NumIn-1:0]    breq_i,
   input  logic [NumIn-1:0]    bgnt_i,
   input  logic [NumIn-1:0]    starv_i,
   output logic [LogNumIn-1:0] prio_o,
   output logic                starve_o,
   output logic [LogNumIn-1:0] lock_idx_o
);

   prio_state_e         state_d, state_q;
   logic [LogNumIn-1:0] prio_d, prio_q, lock_d, lock_q;
   logic [LogNumIn-1:0] cand_all, cand_rest, gnt_idx;
   logic [NumIn-1:0]    starv_rest;
   logic                release_lock;

   always_comb begin
      starv_rest = starv_i & ~(NumIn'(1) << lock_q);
      cand_all   = '0;
      cand_rest  = '0;
      gnt_idx    = '0;
      for (int j = NumIn - 1; j >= 0; j--) begin
         if (starv_i[j]) cand_all = LogNumIn'(j);
         if (starv_rest[j]) cand_rest = LogNumIn'(j);
         if (bgnt_i[j]) gnt_idx = LogNumIn'(j);
      end
      // leaving the bank (drop or readdress) releases the lock just like a grant
      release_lock = bgnt_i[lock_q] || !breq_i[lock_q];
      state_d = state_q;
      prio_d  = prio_q;
      lock_d  = lock_q;
      if (state_q == RR) begin
         if (|starv_i) begin
            state_d = LOCK;
            prio_d  = cand_all;
            lock_d  = cand_all;
         end else if (|bgnt_i) begin
            prio_d = LogNumIn'(wrap_inc(32'(gnt_idx), NumIn));
         end
      end else if (release_lock) begin
         if (|starv_rest) begin
            prio_d = cand_rest;
            lock_d = cand_rest;
         end else begin
            state_d = RR;
            prio_d  = LogNumIn'(wrap_inc(32'(lock_q), NumIn));
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RR;
         prio_q  <= '0;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         lock_q  <= lock_d;
      end
   end

   assign prio_o     = prio_q;
   assign starve_o   = (state_q == LOCK);
   assign lock_idx_o = starve_o ? lock_q : '0;

endmodule

// File: rtl/xbar_varlat_prio_ctrl.sv
// xbar_varlat_prio_ctrl: starvation-aware external priority source for the variable-latency crossbar
module xbar_varlat_prio_ctrl
   import xbar_varlat_pkg::*;
#(
   parameter int unsigned NumIn     = 4,
   parameter int unsigned NumOut    = 4,
   parameter int unsigned MaxWait   = 16,
   parameter int unsigned LogNumIn  = NumIn > 1 ? $clog2(NumIn) : 1,
   parameter int unsigned LogNumOut = NumOut > 1 ? $clog2(NumOut) : 1,
   parameter int unsigned CntWidth  = $clog2(MaxWait + 1)
)(
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NumIn-1:0]                   req_i,
   input  logic [NumIn-1:0][LogNumOut-1:0]    add_i,
   input  logic [NumIn-1:0]                   gnt_i,
   output logic [NumOut-1:0][LogNumIn-1:0]    rr_o,
   output logic [NumOut-1:0]                  starve_o,
   output logic [NumOut-1:0][LogNumIn-1:0]    lock_idx_o
);

   if (NumIn < 2) begin : g_bad_numin
      $error("xbar_varlat_prio_ctrl: NumIn must be at least 2");
   end
   if (MaxWait < 1) begin : g_bad_maxwait
      $error("xbar_varlat_prio_ctrl: MaxWait must be at least 1");
   end

   logic [NumIn-1:0][CntWidth-1:0] cnt_d, cnt_q;
   logic [NumOut-1:0][NumIn-1:0]   breq, bgnt, starv;

   always_comb begin
      breq  = '0;
      bgnt  = '0;
      starv = '0;
      for (int j = 0; j < NumIn; j++) begin
         // the count survives an address change; only a grant or an idle cycle clears it
         cnt_d[j] = (req_i[j] && !gnt_i[j]) ?
                    ((cnt_q[j] == CntWidth'(MaxWait)) ? cnt_q[j] : cnt_q[j] + CntWidth'(1)) : '0;
         for (int k = 0; k < NumOut; k++) begin
            breq[k][j]  = req_i[j] && (add_i[j] == LogNumOut'(k));
            bgnt[k][j]  = breq[k][j] && gnt_i[j];
            starv[k][j] = breq[k][j] && (cnt_q[j] == CntWidth'(MaxWait));
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

   for (genvar k = 0; k < NumOut; k++) begin : g_bank
      xbar_varlat_prio_bank #(
         .NumIn    (NumIn),
         .LogNumIn (LogNumIn)
      ) u_bank (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .breq_i     (breq[k]),
         .bgnt_i     (bgnt[k]),
         .starv_i    (starv[k]),
         .prio_o     (rr_o[k]),
         .starve_o   (starve_o[k]),
         .lock_idx_o (lock_idx_o[k])
      );
   end

endmodule

// File: tb/tb_xbar_varlat_prio_ctrl.sv
// tb_xbar_varlat_prio_ctrl: directed checks of round-robin advance, starvation locks, abort and reset
module tb_xbar_varlat_prio_ctrl;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req, gnt;
   logic [3:0][0:0] add;
   logic [1:0][1:0] rr, lock_idx;
   logic [1:0]      starve;
   int              errors = 0;
   int              checks = 0;

   always #5 clk = ~clk;

   xbar_varlat_prio_ctrl #(
      .NumIn   (4),
      .NumOut  (2),
      .MaxWait (4)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req),
      .add_i      (add),
      .gnt_i      (gnt),
      .rr_o       (rr),
      .starve_o   (starve),
      .lock_idx_o (lock_idx)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_bank(input string tag, input int k, input int e_rr, input int e_st, input int e_lk);
      chk({tag, "_rr"}, 32'(rr[k]), 32'(e_rr));
      chk({tag, "_starve"}, 32'(starve[k]), 32'(e_st));
      chk({tag, "_lock"}, 32'(lock_idx[k]), 32'(e_lk));
   endtask

   initial begin
      rst = 1'b1;
      req = 4'($urandom);
      add = 4'($urandom);
      gnt = '0;
      // reset with random requests
      tick();
      chk_bank("rst1_b0", 0, 0, 0, 0);
      chk_bank("rst1_b1", 1, 0, 0, 0);
      req = 4'($urandom);
      tick();
      chk_bank("rst2_b0", 0, 0, 0, 0);
      chk_bank("rst2_b1", 1, 0, 0, 0);
      rst = 1'b0;
      req = '0;
      add = '0;
      tick();
      chk_bank("post_rst_b0", 0, 0, 0, 0);
      chk_bank("post_rst_b1", 1, 0, 0, 0);
      // round-robin advance and wrap on bank 1
      req[2] = 1'b1; add[2] = 1'b1; gnt[2] = 1'b1;
      tick();
      chk("rr_adv_b1", 32'(rr[1]), 32'd3);
      chk("rr_adv_b0", 32'(rr[0]), 32'd0);
      req = '0; gnt = '0;
      req[3] = 1'b1; add[3] = 1'b1; gnt[3] = 1'b1;
      tick();
      chk("rr_wrap_b1", 32'(rr[1]), 32'd0);
      req = '0; gnt = '0; add = '0;
      tick();
      chk("rr_hold_b1", 32'(rr[1]), 32'd0);
      // starvation of master 1 on bank 0
      req[1] = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk("starve_wait_b0", 32'(starve[0]), 32'd0);
      end
      tick();
      chk_bank("lock_b0", 0, 1, 1, 1);
      req[0] = 1'b1; gnt[0] = 1'b1;
      tick();
      chk_bank("lock_other_gnt1", 0, 1, 1, 1);
      tick();
      chk_bank("lock_other_gnt2", 0, 1, 1, 1);
      req[0] = 1'b0; gnt[0] = 1'b0; gnt[1] = 1'b1;
      tick();
      chk_bank("lock_release_b0", 0, 2, 0, 0);
      req = '0; gnt = '0;
      tick();
      // chained locks on bank 1: masters 0 and 3 starve together
      req[0] = 1'b1; add[0] = 1'b1;
      req[3] = 1'b1; add[3] = 1'b1;
      for (int c = 1; c <= 4; c++) tick();
      chk("chain_wait_b1", 32'(starve[1]), 32'd0);
      tick();
      chk_bank("chain_lock0", 1, 0, 1, 0);
      gnt[0] = 1'b1;
      tick();
      chk_bank("chain_lock3", 1, 3, 1, 3);
      req[0] = 1'b0; gnt[0] = 1'b0; gnt[3] = 1'b1;
      tick();
      chk_bank("chain_release", 1, 0, 0, 0);
      chk("chain_b0_untouched", 32'(rr[0]), 32'd2);
      req = '0; gnt = '0; add = '0;
      tick();
      // abort by dropping the request
      req[2] = 1'b1;
      for (int c = 1; c <= 5; c++) tick();
      chk_bank("abort_lock", 0, 2, 1, 2);
      req[2] = 1'b0;
      tick();
      chk_bank("abort_drop", 0, 3, 0, 0);
      req[2] = 1'b1;
      for (int c = 1; c <= 4; c++) tick();
      chk("abort_cnt_cleared", 32'(starve[0]), 32'd0);
      tick();
      chk_bank("abort_relock", 0, 2, 1, 2);
      // abort by readdressing; saturated count carries over and locks bank 1
      add[2] = 1'b1;
      tick();
      chk_bank("abort_readdr_b0", 0, 3, 0, 0);
      chk_bank("readdr_lock_b1", 1, 2, 1, 2);
      // reset mid-lock
      rst = 1'b1;
      tick();
      chk_bank("midrst_b0", 0, 0, 0, 0);
      chk_bank("midrst_b1", 1, 0, 0, 0);
      rst = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk("relock_wait_b1", 32'(starve[1]), 32'd0);
      end
      tick();
      chk_bank("relock_b1", 1, 2, 1, 2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
